// File: rtl/l2_types_pkg.sv
// Shared L2 types: flush controller state encoding and default set-index width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package l2_types_pkg;

    // Default set-index width for the L2 valid/dirty arrays (16 sets).
    localparam int L2_S_INDEX = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        WB    = 3'd2,
        CLEAR = 3'd3,
        DONE  = 3'd4
    } flush_state_t;

endpackage

// File: rtl/l2_flush_scanner_if.sv
// Bundle between the flush scanner and its neighbours: L2 control
// (flush_req/flush_done/busy), the valid/dirty arrays (read and write ports),
// and the L2 datapath writeback handshake (wb_req/wb_ack).
// Latency: n/a (wiring only). Backpressure: wb_ack gates the writeback.
// master = scanner side, slave = environment side (control, arrays, datapath).
interface l2_flush_scanner_if
    import l2_types_pkg::*;
#(
    parameter int S_INDEX = L2_S_INDEX
) ();
    logic               flush_req;
    logic               flush_done;
    logic               busy;
    logic               arr_read;
    logic [S_INDEX-1:0] arr_rindex;
    logic               arr_valid_in;
    logic               arr_dirty_in;
    logic               arr_load;
    logic [S_INDEX-1:0] arr_windex;
    logic               arr_datain;
    logic               wb_req;
    logic [S_INDEX-1:0] wb_index;
    logic               wb_ack;
    logic [S_INDEX:0]   wb_count;

    modport master (
        input  flush_req, arr_valid_in, arr_dirty_in, wb_ack,
        output flush_done, busy, arr_read, arr_rindex, arr_load, arr_windex,
               arr_datain, wb_req, wb_index, wb_count
    );

    modport slave (
        output flush_req, arr_valid_in, arr_dirty_in, wb_ack,
        input  flush_done, busy, arr_read, arr_rindex, arr_load, arr_windex,
               arr_datain, wb_req, wb_index, wb_count
    );
endinterface

// File: rtl/l2_flush_scanner.sv
// Walks every L2 set on flush_req, writes back each valid+dirty line, then clears its dirty bit.
// Latency: all-clean flush = num_sets cycles to DONE; each dirty line adds 1 + (WB cycles).
// Backpressure: waits indefinitely in WB for wb_ack; flush_req is ignored while busy.
// Ports: clk, rst (async, active-high); bus = l2_flush_scanner_if.master carrying
// the control handshake, array read/write ports and writeback handshake.
module l2_flush_scanner
    import l2_types_pkg::*;
#(
    parameter int s_index = L2_S_INDEX
) (
    input  logic                 clk,
    input  logic                 rst,
    l2_flush_scanner_if.master   bus
);

    localparam logic [s_index-1:0] LAST_IDX = '1;

    flush_state_t       state;
    logic [s_index-1:0] idx;
    logic [s_index:0]   wb_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            wb_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flush_req) begin
                        state    <= SCAN;
                        idx      <= '0;
                        wb_count <= '0;
                    end
                end
                SCAN: begin
                    if (bus.arr_valid_in && bus.arr_dirty_in) begin
                        // Hold idx so WB and CLEAR address the same set.
                        state <= WB;
                    end else if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                WB: begin
                    if (bus.wb_ack) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    wb_count <= wb_count + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= SCAN;
                    end
                end
                DONE: begin
                    // idx only wraps here, never by incrementing past the last set.
                    idx   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore decode: outputs depend on state/idx only, so an async reset
    // forces them all low at once (wb_req drops mid-writeback).
    always_comb begin
        bus.busy       = 1'b0;
        bus.flush_done = 1'b0;
        bus.arr_read   = 1'b0;
        bus.arr_rindex = '0;
        bus.arr_load   = 1'b0;
        bus.arr_windex = '0;
        bus.wb_req     = 1'b0;
        bus.wb_index   = '0;
        case (state)
            SCAN: begin
                bus.busy       = 1'b1;
                bus.arr_read   = 1'b1;
                bus.arr_rindex = idx;
            end
            WB: begin
                bus.busy       = 1'b1;
                bus.arr_rindex = idx;
                bus.wb_req     = 1'b1;
                bus.wb_index   = idx;
            end
            CLEAR: begin
                bus.busy       = 1'b1;
                bus.arr_load   = 1'b1;
                bus.arr_windex = idx;
            end
            DONE: begin
                bus.busy       = 1'b1;
                bus.flush_done = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    // Clearing is the only write this block ever performs.
    assign bus.arr_datain = 1'b0;
    assign bus.wb_count   = wb_count;

endmodule
